// File: rtl/qnigma_prng_chk.sv
// Receive-side checker for the qnigma_prng LFSR word stream: self-synchronises,
// predicts each next word and reports lock status and saturating bit-error statistics.
module qnigma_prng_chk #(
  parameter int           W        = 32,
  parameter logic [W-1:0] POLY     = 32'h80200003,
  parameter logic         IN_BIT   = 1'b0,
  parameter int           LOCK_CNT = 8,
  parameter int           LOSS_CNT = 4,
  parameter int           CW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_val,
  input  logic [W-1:0]  in_dat,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] word_cnt,
  output logic [CW-1:0] err_bits
);

  localparam int MW = $clog2(LOCK_CNT) + 1;
  localparam int LW = $clog2(LOSS_CNT) + 1;
  localparam int PW = $clog2(W + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  exp_q, exp_d;
  logic [MW-1:0] match_q, match_d;
  logic [LW-1:0] miss_q, miss_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [CW-1:0] err_bits_q, err_bits_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;

  logic [PW-1:0] diff_bits;
  logic [CW:0]   err_sum;

  function automatic logic [W-1:0] step(input logic [W-1:0] x);
    logic [W-1:0] sh;
    sh = {IN_BIT, x[W-1:1]};
    return x[0] ? (sh ^ POLY) : sh;
  endfunction

  function automatic logic [PW-1:0] popcount(input logic [W-1:0] x);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + PW'(x[i]);
    return c;
  endfunction

  assign diff_bits = popcount(in_dat ^ exp_q);
  assign err_sum   = {1'b0, err_bits_q} + (CW+1)'(diff_bits);

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    match_d    = match_q;
    miss_d     = miss_q;
    word_cnt_d = word_cnt_q;
    err_bits_d = err_bits_q;
    err_d      = 1'b0;

    case (state_q)
      SEARCH: begin
        // An all-zero word is the LFSR lock-up value and can never seed a prediction.
        if (in_val && in_dat != '0) begin
          exp_d   = step(in_dat);
          match_d = '0;
          state_d = VERIFY;
        end
      end
      VERIFY: begin
        if (in_val) begin
          if (in_dat == exp_q) begin
            exp_d   = step(exp_q);
            match_d = match_q + 1'b1;
            if (match_q == MW'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (in_dat == '0) begin
            match_d = '0;
            state_d = SEARCH;
          end else begin
            exp_d   = step(in_dat);
            match_d = '0;
          end
        end
      end
      LOCKED: begin
        if (in_val) begin
          // Prediction free-runs here so a corrupted word cannot derail it.
          exp_d      = step(exp_q);
          word_cnt_d = (word_cnt_q == '1) ? word_cnt_q : word_cnt_q + 1'b1;
          if (in_dat != exp_q) begin
            err_d      = 1'b1;
            err_bits_d = err_sum[CW] ? '1 : err_sum[CW-1:0];
            miss_d     = miss_q + 1'b1;
            if (miss_q == LW'(LOSS_CNT - 1)) state_d = SEARCH;
          end else begin
            miss_d = '0;
          end
        end
      end
      default: state_d = SEARCH;
    endcase

    if (clr) begin
      word_cnt_d = '0;
      err_bits_d = '0;
    end
  end

  assign locked_d = (state_d == LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SEARCH;
      exp_q      <= '0;
      match_q    <= '0;
      miss_q     <= '0;
      word_cnt_q <= '0;
      err_bits_q <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      match_q    <= match_d;
      miss_q     <= miss_d;
      word_cnt_q <= word_cnt_d;
      err_bits_q <= err_bits_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  assign locked   = locked_q;
  assign err      = err_q;
  assign word_cnt = word_cnt_q;
  assign err_bits = err_bits_q;

endmodule

// File: tb/tb_qnigma_prng_chk.sv
// Scoreboard bench for qnigma_prng_chk: directed generator streams with hand-derived
// expected lock/err/counter values; counters are 8 bits wide so saturation is reachable.
module tb_qnigma_prng_chk;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          in_val = 1'b0;
  logic [31:0]   in_dat = '0;
  logic          locked, err;
  logic [CW-1:0] word_cnt, err_bits;

  typedef struct packed {
    logic          locked;
    logic          err;
    logic [CW-1:0] wc;
    logic [CW-1:0] eb;
  } exp_t;

  exp_t   exp_q[$];
  string  name_q[$];
  logic   issue = 1'b0;
  logic   issued_q = 1'b0;
  int     checks = 0;
  int     failures = 0;
  logic [31:0] g;

  qnigma_prng_chk #(.CW(CW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_val(in_val), .in_dat(in_dat),
    .locked(locked), .err(err), .word_cnt(word_cnt), .err_bits(err_bits)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] gstep(input logic [31:0] x);
    logic [31:0] sh;
    sh = {1'b0, x[31:1]};
    return x[0] ? (sh ^ 32'h80200003) : sh;
  endfunction

  task automatic checkOutput(input string nm, input exp_t e);
    checks += 4;
    if (locked !== e.locked) begin
      failures++;
      $display("[TB] FAIL %s locked got=%0b want=%0b", nm, locked, e.locked);
    end
    if (err !== e.err) begin
      failures++;
      $display("[TB] FAIL %s err got=%0b want=%0b", nm, err, e.err);
    end
    if (word_cnt !== e.wc) begin
      failures++;
      $display("[TB] FAIL %s word_cnt got=%0d want=%0d", nm, word_cnt, e.wc);
    end
    if (err_bits !== e.eb) begin
      failures++;
      $display("[TB] FAIL %s err_bits got=%0d want=%0d", nm, err_bits, e.eb);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic c,
                               input string nm, input exp_t e);
    @(negedge clk);
    in_val = v;
    in_dat = d;
    clr    = c;
    issue  = v | c;
    if (v | c) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
  endtask

  task automatic sendWord(input logic [31:0] d, input logic c, input string nm,
                          input logic l, input logic e, input int wc, input int eb);
    exp_t x;
    x.locked = l;
    x.err    = e;
    x.wc     = CW'(wc);
    x.eb     = CW'(eb);
    applyStimulus(1'b1, d, c, nm, x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, $urandom, 1'b0, "idle", '0);
  endtask

  // Monitor: one registered response appears per issued cycle.
  always @(posedge clk) issued_q <= issue;

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (issued_q) begin
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL scoreboard_underflow got=empty want=entry");
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          checkOutput(nm, e);
        end
      end
    end
  end

  initial begin : stim
    int wc, eb, k;
    exp_t z;
    z = '0;

    #12;
    checkOutput("reset_init", z);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    g = 32'hdeadbeef;
    for (int i = 0; i < 9; i++) begin
      sendWord(g, 1'b0, "lock", i == 8, 1'b0, 0, 0);
      g = gstep(g);
    end
    for (int i = 1; i <= 3; i++) begin
      sendWord(g, 1'b0, "locked_clean", 1'b1, 1'b0, i, 0);
      g = gstep(g);
    end

    sendWord(g ^ 32'h5, 1'b0, "single_err", 1'b1, 1'b1, 4, 2);
    g = gstep(g);
    for (int i = 5; i <= 6; i++) begin
      sendWord(g, 1'b0, "after_err", 1'b1, 1'b0, i, 2);
      g = gstep(g);
    end

    sendWord(g ^ 32'hf, 1'b1, "clr_err", 1'b1, 1'b1, 0, 0);
    g = gstep(g);
    sendWord(g, 1'b0, "after_clr", 1'b1, 1'b0, 1, 0);
    g = gstep(g);

    for (int i = 1; i <= 4; i++) begin
      sendWord(g ^ 32'hff, 1'b0, "loss", i < 4, 1'b1, 1 + i, 8 * i);
      g = gstep(g);
    end
    for (int i = 0; i < 3; i++) sendWord(32'h0, 1'b0, "zero_ignored", 1'b0, 1'b0, 5, 32);
    for (int i = 0; i < 9; i++) begin
      sendWord(g, 1'b0, "relock", i == 8, 1'b0, 5, 32);
      g = gstep(g);
    end
    idle(2);

    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("reset_midlock", z);
    @(negedge clk);
    rst = 1'b1;
    idle(1);

    g = 32'hdeadbeef;
    for (int i = 0; i < 9; i++) begin
      idle($urandom_range(0, 2));
      sendWord(g, 1'b0, "gap_lock", i == 8, 1'b0, 0, 0);
      g = gstep(g);
    end

    // Alternate fully-inverted and clean words so err_bits saturates without losing lock.
    eb = 0;
    for (k = 1; k <= 260; k++) begin
      wc = (k > 255) ? 255 : k;
      if (k <= 16 && (k % 2) == 1) begin
        eb = (eb + 32 > 255) ? 255 : eb + 32;
        sendWord(~g, 1'b0, "sat_err", 1'b1, 1'b1, wc, eb);
      end else begin
        sendWord(g, 1'b0, "sat_clean", 1'b1, 1'b0, wc, eb);
      end
      g = gstep(g);
    end
    sendWord(g ^ 32'h1, 1'b0, "sat_hold", 1'b1, 1'b1, 255, 255);
    idle(1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
